// File: rtl/lse_mult_arbiter.sv
// Round-robin arbiter sharing one log-space multiplier (sum of logs) between NUM_REQ requesters.
// Optional macro LSE_MULT_SAT_EN: saturate signed overflow instead of wrapping.
module lse_mult_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 24,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [ID_W-1:0]          out_id,
  output logic [15:0]              op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Log-space product; -inf on either input dominates everything else.
  function automatic logic [WIDTH-1:0] lse_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ninf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res;
    ninf = {1'b1, {(WIDTH-1){1'b0}}};
    sum  = a + b;
    res  = sum;
`ifdef LSE_MULT_SAT_EN
    // Negative clamp stops one short of the -inf code so a finite sum never reads as -inf.
    if (!a[WIDTH-1] && !b[WIDTH-1] && sum[WIDTH-1]) begin
      res = {1'b0, {(WIDTH-1){1'b1}}};
    end else if ((a[WIDTH-1] && b[WIDTH-1] && !sum[WIDTH-1]) || (sum == ninf)) begin
      res = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    end else begin
      res = sum;
    end
`endif
    return ((a == ninf) || (b == ninf)) ? ninf : res;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    ptr_nxt_s;
  logic [ID_W-1:0]    win_id_s;
  logic               found_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               can_load_s;
  logic               accept_s;
  logic [WIDTH-1:0]   op_a_s;
  logic [WIDTH-1:0]   op_b_s;
  logic [WIDTH-1:0]   out_result_r;
  logic [ID_W-1:0]    out_id_r;
  logic [15:0]        op_count_r;

  // Round-robin search from rr_ptr; scanning backwards leaves the nearest valid requester as winner.
  always_comb begin
    win_id_s = '0;
    found_s  = |req_valid;
    grant_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx      = int'(rr_ptr_r) + k;
      idx      = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
      win_id_s = req_valid[idx] ? ID_W'(idx) : win_id_s;
    end
    grant_s[win_id_s] = found_s;
  end

  assign can_load_s = (state_r == EMPTY) || out_ready;
  assign req_ready  = grant_s & {NUM_REQ{can_load_s}};
  assign accept_s   = found_s && can_load_s;
  assign op_a_s     = req_operand_a[int'(win_id_s)*WIDTH +: WIDTH];
  assign op_b_s     = req_operand_b[int'(win_id_s)*WIDTH +: WIDTH];
  assign ptr_nxt_s  = (int'(win_id_s) == NUM_REQ - 1) ? '0 : (win_id_s + ID_W'(1));

  // Output stage next-state: an accept always (re)fills, a drain without accept empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s || !out_ready) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, result register, arbitration pointer and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= EMPTY;
      rr_ptr_r     <= '0;
      out_result_r <= '0;
      out_id_r     <= '0;
      op_count_r   <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        out_result_r <= lse_mul(op_a_s, op_b_s);
        out_id_r     <= win_id_s;
        rr_ptr_r     <= ptr_nxt_s;
      end
      if ((state_r == FULL) && out_ready) begin
        op_count_r <= op_count_r + 16'd1;
      end
    end
  end

  assign out_valid  = (state_r == FULL);
  assign out_result = out_result_r;
  assign out_id     = out_id_r;
  assign op_count   = op_count_r;

endmodule

// File: tb/tb_lse_mult_arbiter.sv
// Directed self-checking bench for lse_mult_arbiter (NUM_REQ=4, WIDTH=24).
module tb_lse_mult_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [95:0] opa;
  logic [95:0] opb;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_result;
  logic [1:0]  out_id;
  logic [15:0] op_count;
  int n_checks = 0;
  int n_fail   = 0;

  lse_mult_arbiter #(.NUM_REQ(4), .WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_operand_a(opa), .req_operand_b(opb), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_id(out_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
    opa[i*24 +: 24] = a;
    opb[i*24 +: 24] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 4'h0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 24'(i * 16), 24'h000001);
    repeat (3) step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", op_count); end
    n_checks++; if (out_result !== 24'h0 || out_id !== 2'd0) begin n_fail++; $display("FAIL reset_regs: got %h/%0d expected 0/0", out_result, out_id); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_result !== 24'h000001) begin
      n_fail++; $display("FAIL reset_first_result: got v=%b id=%0d r=%h expected 1/0/000001", out_valid, out_id, out_result); end
    req_valid = 4'h0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b expected 0000", req_ready); end
    step(); step();
    n_checks++; if (out_valid !== 1'b0 || op_count !== 16'd1) begin n_fail++; $display("FAIL idle_state: got v=%b cnt=%0d expected 0/1", out_valid, op_count); end
  endtask

  task automatic test_single();
    do_reset();
    set_op(2, 24'h000100, 24'h000023);
    req_valid = 4'b0100; out_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    step();
    req_valid = 4'h0;
    n_checks++; if (out_valid !== 1'b1 || out_result !== 24'h000123 || out_id !== 2'd2) begin
      n_fail++; $display("FAIL single_result: got v=%b r=%h id=%0d expected 1/000123/2", out_valid, out_result, out_id); end
    step();
    n_checks++; if (op_count !== 16'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_count: got cnt=%0d v=%b expected 1/0", op_count, out_valid); end
  endtask

  task automatic test_round_robin();
    logic [23:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 24'(i * 256), 24'(i));
    req_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      e = 24'(c % 4) * 24'h000101;
      n_checks++; if (out_valid !== 1'b1 || out_id !== 2'(c % 4) || out_result !== e) begin
        n_fail++; $display("FAIL rr_cycle%0d: got v=%b id=%0d r=%h expected 1/%0d/%h", c, out_valid, out_id, out_result, c % 4, e); end
    end
    n_checks++; if (op_count !== 16'd5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", op_count); end
    req_valid = 4'h0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(1, 24'h000200, 24'h000003);
    set_op(3, 24'h000300, 24'h000004);
    req_valid = 4'b0010; out_ready = 1'b0;
    step();
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 0000", c, req_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_result !== 24'h000203 || out_id !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b r=%h id=%0d expected 1/000203/1", c, out_valid, out_result, out_id); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1000", req_ready); end
    step();
    req_valid = 4'h0;
    n_checks++; if (out_valid !== 1'b1 || out_result !== 24'h000304 || out_id !== 2'd3 || op_count !== 16'd1) begin
      n_fail++; $display("FAIL bp_refill: got v=%b r=%h id=%0d cnt=%0d expected 1/000304/3/1", out_valid, out_result, out_id, op_count); end
    step();
    n_checks++; if (out_valid !== 1'b0 || op_count !== 16'd2) begin n_fail++; $display("FAIL bp_drain: got v=%b cnt=%0d expected 0/2", out_valid, op_count); end
  endtask

  task automatic test_special();
    logic [23:0] e_pos;
    logic [23:0] e_neg;
`ifdef LSE_MULT_SAT_EN
    e_pos = 24'h7FFFFF; e_neg = 24'h800001;
`else
    e_pos = 24'hFFFFE0; e_neg = 24'h000020;
`endif
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1;
    set_op(0, 24'h800000, 24'h000005);
    step();
    n_checks++; if (out_result !== 24'h800000) begin n_fail++; $display("FAIL ninf_a: got %h expected 800000", out_result); end
    set_op(0, 24'h000005, 24'h800000);
    step();
    n_checks++; if (out_result !== 24'h800000) begin n_fail++; $display("FAIL ninf_b: got %h expected 800000", out_result); end
    set_op(0, 24'h7FFFF0, 24'h7FFFF0);
    step();
    n_checks++; if (out_result !== e_pos) begin n_fail++; $display("FAIL pos_overflow: got %h expected %h", out_result, e_pos); end
    set_op(0, 24'h800010, 24'h800010);
    step();
    n_checks++; if (out_result !== e_neg) begin n_fail++; $display("FAIL neg_overflow: got %h expected %h", out_result, e_neg); end
    set_op(0, 24'hFFFFFE, 24'h000005);
    step();
    req_valid = 4'h0;
    n_checks++; if (out_result !== 24'h000003) begin n_fail++; $display("FAIL signed_add: got %h expected 000003", out_result); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    set_op(0, 24'h000001, 24'h000001);
    req_valid = 4'b0001; out_ready = 1'b1;
    repeat (65536) step();
    n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL count_max: got %h expected ffff", op_count); end
    step();
    n_checks++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL count_wrap: got %h expected 0000", op_count); end
    req_valid = 4'h0; out_ready = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_full: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || op_count !== 16'd0) begin n_fail++; $display("FAIL midrst_async: got v=%b cnt=%0d expected 0/0", out_valid, op_count); end
    step();
    rst_n = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_restart: got %b expected 0001", req_ready); end
    step();
    req_valid = 4'h0;
    n_checks++; if (out_id !== 2'd0 || op_count !== 16'd0) begin n_fail++; $display("FAIL midrst_first: got id=%0d cnt=%0d expected 0/0", out_id, op_count); end
  endtask

  initial begin
    opa = '0; opb = '0; req_valid = 4'h0; out_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_special();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
